// File: rtl/roi_shell_pkg.sv
// Shared types and helpers for the reconfigurable-partition static shell.
// Holds the decoupler state encoding and the blink limit function.
package roi_shell_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DECOUPLED = 2'd1,
    RELEASE   = 2'd2
  } state_e;

  function automatic longint unsigned lim(
    input longint unsigned base,
    input int unsigned     i
  );
    return base * (64'(i) + 64'd1);
  endfunction

endpackage

// File: rtl/blink_divider.sv
// Free-running blink channel: counts 0..LIMIT, toggles blink on wrap.
// Period of the blink output is 2*(LIMIT+1) cycles.
module blink_divider #(
  parameter int              CNT_W = 32,
  parameter longint unsigned LIMIT = 64'd4
) (
  input  logic clk,
  input  logic rst,
  output logic blink
);

  localparam logic [CNT_W-1:0] LIM = LIMIT[CNT_W-1:0];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    blink_d = blink_q;
    if (cnt_q == LIM) begin
      cnt_d   = '0;
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;

endmodule

// File: rtl/roi_static_shell.sv
// Static shell: blink channels, RP output decoupler and RP reset pulser.
// All outputs come straight from flops.
module roi_static_shell
  import roi_shell_pkg::*;
#(
  parameter int              DOUT_N      = 3,
  parameter int              BLINK_N     = 2,
  parameter int              CNT_W       = 32,
  parameter longint unsigned PERIOD_BASE = 64'd10000000,
  parameter int              RST_PULSE   = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic [BLINK_N-1:0] blinky,
  input  logic [DOUT_N-1:0]  rp_dout,
  output logic [DOUT_N-1:0]  dout,
  input  logic               decouple_req,
  output logic               decouple_ack,
  output logic               rp_rst
);

  localparam int PW = $clog2(RST_PULSE + 1);
  localparam logic [PW-1:0] PLAST = PW'(RST_PULSE - 1);

  if (RST_PULSE < 1) begin : g_bad_pulse
    $error("RST_PULSE must be at least 1");
  end

  for (genvar i = 0; i < BLINK_N; i++) begin : g_blink
    localparam longint unsigned L = lim(PERIOD_BASE, i);
    if (L >= (64'd1 << CNT_W)) begin : g_bad_lim
      $error("blink limit does not fit in CNT_W");
    end
    blink_divider #(
      .CNT_W (CNT_W),
      .LIMIT (L)
    ) u_blink (
      .clk   (clk),
      .rst   (rst),
      .blink (blinky[i])
    );
  end

  state_e              state_q, state_d;
  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic [DOUT_N-1:0]   dout_q, dout_d;
  logic                ack_q, ack_d;
  logic                rp_rst_q, rp_rst_d;

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    dout_d  = dout_q;
    unique case (state_q)
      RUN: begin
        pcnt_d = '0;
        if (decouple_req) state_d = DECOUPLED;
        else              dout_d  = rp_dout;
      end
      DECOUPLED: begin
        if (!decouple_req) begin
          state_d = RELEASE;
          pcnt_d  = '0;
        end
      end
      RELEASE: begin
        // request is deliberately ignored until the pulse completes
        if (pcnt_q == PLAST) begin
          state_d = RUN;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      default: begin
        state_d = RELEASE;
        pcnt_d  = '0;
      end
    endcase
    ack_d    = (state_d != RUN);
    rp_rst_d = (state_d == RELEASE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RELEASE;
      pcnt_q   <= '0;
      dout_q   <= '0;
      ack_q    <= 1'b1;
      rp_rst_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      dout_q   <= dout_d;
      ack_q    <= ack_d;
      rp_rst_q <= rp_rst_d;
    end
  end

  assign dout         = dout_q;
  assign decouple_ack = ack_q;
  assign rp_rst       = rp_rst_q;

endmodule
